// File: rtl/acc_seq_pkg.sv
// Shared widths and state encoding for the accumulator sequencer and its accumulator.
package acc_seq_pkg;

  localparam int ACC_DATA_WIDTH = 8;
  localparam int ACC_CNT_WIDTH  = 8;
  localparam int FRAME_CNT_W    = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    RUN     = 3'd2,
    DRAIN   = 3'd3,
    CAPTURE = 3'd4,
    RESULT  = 3'd5
  } acc_seq_state_e;

  // Final accept of a frame: counter has reached len-1 (len is never 0 in RUN).
  function automatic logic is_last_sample(input logic [ACC_CNT_WIDTH-1:0] cnt,
                                          input logic [ACC_CNT_WIDTH-1:0] len);
    return cnt == (len - ACC_CNT_WIDTH'(1));
  endfunction

endpackage

// File: rtl/acc_seq_acc.sv
// Frame accumulator: clear has priority over enable; sum wraps modulo 2^DATA_WIDTH.
module acc_seq_acc
  import acc_seq_pkg::*;
#(
  parameter int DATA_WIDTH = ACC_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  acc_enable,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] data_out
);

  always_ff @(posedge clk) begin
    if (reset || clear) data_out <= '0;
    else if (acc_enable) data_out <= data_out + data_in;
  end

endmodule

// File: rtl/acc_seq_top.sv
// Integration wrapper: sequencer plus accumulator, exposing only stream and result ports.
module acc_seq_top
  import acc_seq_pkg::*;
#(
  parameter int DATA_WIDTH = ACC_DATA_WIDTH,
  parameter int CNT_WIDTH  = ACC_CNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CNT_WIDTH-1:0]   frame_len,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_WIDTH-1:0]  res_data,
  output logic                   res_valid,
  input  logic                   res_ready,
`ifdef ACC_SEQ_FRAME_CNT_EN
  output logic [FRAME_CNT_W-1:0] frame_cnt,
`endif
  output logic                   busy
);

  logic [DATA_WIDTH-1:0] acc_data;
  logic                  acc_enable;
  logic                  acc_clear;
  logic [DATA_WIDTH-1:0] acc_result;

  acc_seq #(.DATA_WIDTH(DATA_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_seq (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .frame_len  (frame_len),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .acc_data   (acc_data),
    .acc_enable (acc_enable),
    .acc_clear  (acc_clear),
    .acc_result (acc_result),
    .res_data   (res_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
`ifdef ACC_SEQ_FRAME_CNT_EN
    .frame_cnt  (frame_cnt),
`endif
    .busy       (busy)
  );

  acc_seq_acc #(.DATA_WIDTH(DATA_WIDTH)) u_acc (
    .clk        (clk),
    .reset      (reset),
    .data_in    (acc_data),
    .acc_enable (acc_enable),
    .clear      (acc_clear),
    .data_out   (acc_result)
  );

endmodule

// File: rtl/acc_seq.sv
// Sample-stream framer driving the accumulator and returning one sum per frame.
// Optional frame counter output enabled by defining ACC_SEQ_FRAME_CNT_EN.
module acc_seq
  import acc_seq_pkg::*;
#(
  parameter int DATA_WIDTH = ACC_DATA_WIDTH,
  parameter int CNT_WIDTH  = ACC_CNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CNT_WIDTH-1:0]   frame_len,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_WIDTH-1:0]  acc_data,
  output logic                   acc_enable,
  output logic                   acc_clear,
  input  logic [DATA_WIDTH-1:0]  acc_result,
  output logic [DATA_WIDTH-1:0]  res_data,
  output logic                   res_valid,
  input  logic                   res_ready,
`ifdef ACC_SEQ_FRAME_CNT_EN
  output logic [FRAME_CNT_W-1:0] frame_cnt,
`endif
  output logic                   busy
);

  acc_seq_state_e       state;
  logic [CNT_WIDTH-1:0] len_q;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 accept;
  logic                 last;

  assign in_ready = (state == RUN);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign last     = (cnt == (len_q - CNT_WIDTH'(1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      len_q      <= '0;
      cnt        <= '0;
      acc_data   <= '0;
      acc_enable <= 1'b0;
      acc_clear  <= 1'b0;
      res_data   <= '0;
      res_valid  <= 1'b0;
`ifdef ACC_SEQ_FRAME_CNT_EN
      frame_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          acc_enable <= 1'b0;
          if (start) begin
            len_q     <= frame_len;
            cnt       <= '0;
            acc_clear <= 1'b1;
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          // Accumulator clears on the edge leaving this state.
          acc_clear <= 1'b0;
          state     <= (len_q == '0) ? DRAIN : RUN;
        end
        RUN: begin
          if (accept) begin
            acc_data   <= in_data;
            acc_enable <= 1'b1;
            cnt        <= cnt + CNT_WIDTH'(1);
            if (last) state <= DRAIN;
          end else begin
            acc_enable <= 1'b0;
          end
        end
        DRAIN: begin
          // Final sample's enable is live this cycle; sum settles on the exit edge.
          acc_enable <= 1'b0;
          state      <= CAPTURE;
        end
        CAPTURE: begin
          res_data  <= acc_result;
          res_valid <= 1'b1;
          state     <= RESULT;
        end
        RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
`ifdef ACC_SEQ_FRAME_CNT_EN
            frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (!(acc_enable && acc_clear));
  end

endmodule

// File: tb/tb_acc_seq.sv
// Directed bench for acc_seq: table of frames plus reset/backpressure sequences,
// with a behavioural accumulator closing the loop on acc_result.
module tb_acc_seq;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, res_ready;
  logic [7:0]  frame_len, in_data, acc_result;
  logic        in_ready, acc_enable, acc_clear, res_valid, busy;
  logic [7:0]  acc_data, res_data;
`ifdef ACC_SEQ_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  always #5 clk = ~clk;

  acc_seq dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .frame_len  (frame_len),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .acc_data   (acc_data),
    .acc_enable (acc_enable),
    .acc_clear  (acc_clear),
    .acc_result (acc_result),
    .res_data   (res_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
`ifdef ACC_SEQ_FRAME_CNT_EN
    .frame_cnt  (frame_cnt),
`endif
    .busy       (busy)
  );

  // Accumulator model
  logic [7:0] acc_q;
  always @(posedge clk) begin
    if (reset || acc_clear) acc_q <= 8'd0;
    else if (acc_enable) acc_q <= acc_q + acc_data;
  end
  assign acc_result = acc_q;

  int en_hi = 0, clr_hi = 0, rdy_hi = 0, excl_viol = 0;
  always @(negedge clk) begin
    if (acc_enable) en_hi++;
    if (acc_clear) clr_hi++;
    if (in_ready) rdy_hi++;
    if (acc_enable && acc_clear) excl_viol++;
  end

  int total = 0, bad = 0, fc_exp = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [7:0]      len;
    logic [3:0][7:0] s;
    logic [3:0][3:0] gap;
    logic [7:0]      exp;
    logic [3:0]      hold;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] len, input logic [31:0] s,
                              input logic [15:0] gap, input logic [7:0] exp,
                              input logic [3:0] hold);
    vec_t v;
    v.len = len; v.s = s; v.gap = gap; v.exp = exp; v.hold = hold;
    return v;
  endfunction

  task automatic check_all_zero(input string nm);
    check({nm, "_in_ready"}, in_ready, 0);
    check({nm, "_acc_data"}, acc_data, 0);
    check({nm, "_acc_enable"}, acc_enable, 0);
    check({nm, "_acc_clear"}, acc_clear, 0);
    check({nm, "_res_data"}, res_data, 0);
    check({nm, "_res_valid"}, res_valid, 0);
    check({nm, "_busy"}, busy, 0);
`ifdef ACC_SEQ_FRAME_CNT_EN
    check({nm, "_frame_cnt"}, frame_cnt, 0);
`endif
  endtask

  task automatic feed(input logic [7:0] d, input string nm);
    int k = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && k < 20) begin tick; k++; end
    check({nm, "_ready_wait"}, (k < 20), 1);
    tick;
    in_valid = 1'b0;
    in_data  = 8'd0;
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int e0 = en_hi, c0 = clr_hi, r0 = rdy_hi, lat = 0;
    frame_len = v.len;
    start = 1'b1;
    tick;
    start = 1'b0;
    frame_len = ~v.len;  // must be ignored once latched
    check({tag, "_clear_pulse"}, acc_clear, 1);
    check({tag, "_busy"}, busy, 1);
    for (int i = 0; i < int'(v.len); i++) begin
      repeat (int'(v.gap[i])) tick;
      feed(v.s[i], tag);
    end
    while (!res_valid && lat < 20) begin tick; lat++; end
    check({tag, "_latency"}, lat, (v.len == 0) ? 3 : 2);
    check({tag, "_res_data"}, res_data, v.exp);
    check({tag, "_enable_cycles"}, en_hi - e0, v.len);
    check({tag, "_clear_cycles"}, clr_hi - c0, 1);
    if (v.len == 0) check({tag, "_ready_cycles"}, rdy_hi - r0, 0);
    if (v.hold != 0) begin
      start = 1'b1;
      frame_len = 8'd3;
      repeat (int'(v.hold)) begin
        tick;
        check({tag, "_hold_valid"}, res_valid, 1);
        check({tag, "_hold_data"}, res_data, v.exp);
      end
      start = 1'b0;
      check({tag, "_hold_no_clear"}, clr_hi - c0, 1);
    end
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    fc_exp++;
    check({tag, "_valid_drop"}, res_valid, 0);
    check({tag, "_idle"}, busy, 0);
`ifdef ACC_SEQ_FRAME_CNT_EN
    check({tag, "_frame_cnt"}, frame_cnt, fc_exp);
`endif
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = mk(8'd4, {8'd4, 8'd3, 8'd2, 8'd1},   {4'd0, 4'd0, 4'd0, 4'd0}, 8'd10,  4'd0);
    vecs[1] = mk(8'd3, {8'd0, 8'd9, 8'd7, 8'd5},   {4'd0, 4'd2, 4'd1, 4'd0}, 8'd21,  4'd0);
    vecs[2] = mk(8'd2, {8'd0, 8'd0, 8'd12, 8'd30}, {4'd0, 4'd0, 4'd0, 4'd0}, 8'd42,  4'd5);
    vecs[3] = mk(8'd0, {8'd0, 8'd0, 8'd0, 8'd0},   {4'd0, 4'd0, 4'd0, 4'd0}, 8'd0,   4'd0);
    vecs[4] = mk(8'd2, {8'd0, 8'd0, 8'd100, 8'd200}, {4'd0, 4'd0, 4'd0, 4'd0}, 8'd44, 4'd0);
    vecs[5] = mk(8'd1, {8'd0, 8'd0, 8'd0, 8'd255}, {4'd0, 4'd0, 4'd0, 4'd0}, 8'd255, 4'd0);

    reset = 1'b1; start = 1'b0; frame_len = 8'd0; in_data = 8'd0;
    in_valid = 1'b0; res_ready = 1'b0;
    tick; tick;
    check_all_zero("reset");
    reset = 1'b0;
    tick;
    check("idle_after_reset", busy, 0);

    for (int i = 0; i < 6; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of RUN, after two of four samples.
    frame_len = 8'd4;
    start = 1'b1;
    tick;
    start = 1'b0;
    feed(8'd7, "midrun");
    feed(8'd9, "midrun");
    check("midrun_in_run", in_ready, 1);
    reset = 1'b1;
    tick;
    fc_exp = 0;
    check_all_zero("midrun_reset");
    reset = 1'b0;
    tick;
    check("midrun_still_idle", busy, 0);
    run_frame(mk(8'd4, {8'd1, 8'd1, 8'd1, 8'd1}, 16'd0, 8'd4, 4'd0), "after_reset");
    run_frame(mk(8'd2, {8'd0, 8'd0, 8'd5, 8'd6}, 16'd0, 8'd11, 4'd0), "second");
    run_frame(mk(8'd1, {8'd0, 8'd0, 8'd0, 8'd3}, 16'd0, 8'd3, 4'd0), "third");

    check("enable_clear_exclusive", excl_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
